// File: rtl/program_loader.sv
// program_loader: assembles big-endian byte pairs into 16-bit instructions and writes them to
// instruction memory while holding the CPU in reset. Optional trailing checksum byte: PROGRAM_LOADER_CHECKSUM_EN.
module program_loader #(
  parameter logic [15:0] BASE_ADDR = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] word_count,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic [15:0] instruction_in,
  output logic [15:0] load_address,
  output logic        load_instruction,
  output logic        pc_reset,
  output logic        busy,
  output logic        done,
  output logic        error
);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, HI, LO, WRITE, CHK, DONE, ERROR} state_t;
  localparam state_t END_STATE = CHK;
`else
  typedef enum logic [2:0] {IDLE, HI, LO, WRITE, DONE} state_t;
  localparam state_t END_STATE = DONE;
`endif

  state_t      state_q, state_d;
  logic [15:0] instr_q, instr_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] remaining_q, remaining_d;
  logic        byte_ready_q, byte_ready_d;
  logic        load_q, load_d;
  logic        pc_reset_q, pc_reset_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        accept;
  logic        can_start;

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [7:0]  csum_q, csum_d;
  logic        error_q, error_d;
`endif

  // byte_ready is registered from the next state, so it is a clean function of the current state
  assign accept    = byte_ready_q & byte_valid;
  assign can_start = start & ((state_q == IDLE) | (state_q == DONE)
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                              | (state_q == ERROR)
`endif
                             );

  always_comb begin
    state_d     = state_q;
    instr_d     = instr_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    csum_d      = csum_q;
`endif
    case (state_q)
      HI: begin
        if (accept) begin
          instr_d[15:8] = byte_in;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          csum_d        = csum_q ^ byte_in;
`endif
          state_d       = LO;
        end
      end
      LO: begin
        if (accept) begin
          instr_d[7:0] = byte_in;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          csum_d       = csum_q ^ byte_in;
`endif
          state_d      = WRITE;
        end
      end
      WRITE: begin
        addr_d      = addr_q + 16'd1;
        remaining_d = remaining_q - 16'd1;
        state_d     = (remaining_q != 16'd1) ? HI : END_STATE;
      end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      CHK: begin
        if (accept) begin
          state_d = (byte_in == csum_q) ? DONE : ERROR;
        end
      end
`endif
      default: begin
      end
    endcase

    if (can_start) begin
      addr_d      = BASE_ADDR;
      remaining_d = word_count;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      csum_d      = 8'h00;
`endif
      state_d     = (word_count != 16'd0) ? HI : END_STATE;
    end
  end

  // Status outputs are decoded from the next state so they change together with the state register
  always_comb begin
    load_d     = (state_d == WRITE);
    pc_reset_d = (state_d != DONE);
    done_d     = (state_d == DONE);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    byte_ready_d = (state_d == HI) | (state_d == LO) | (state_d == CHK);
    busy_d       = (state_d == HI) | (state_d == LO) | (state_d == WRITE) | (state_d == CHK);
    error_d      = (state_d == ERROR);
`else
    byte_ready_d = (state_d == HI) | (state_d == LO);
    busy_d       = (state_d == HI) | (state_d == LO) | (state_d == WRITE);
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      instr_q      <= 16'h0000;
      addr_q       <= BASE_ADDR;
      remaining_q  <= 16'h0000;
      byte_ready_q <= 1'b0;
      load_q       <= 1'b0;
      pc_reset_q   <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      csum_q       <= 8'h00;
      error_q      <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      instr_q      <= instr_d;
      addr_q       <= addr_d;
      remaining_q  <= remaining_d;
      byte_ready_q <= byte_ready_d;
      load_q       <= load_d;
      pc_reset_q   <= pc_reset_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      csum_q       <= csum_d;
      error_q      <= error_d;
`endif
    end
  end

  assign byte_ready       = byte_ready_q;
  assign instruction_in   = instr_q;
  assign load_address     = addr_q;
  assign load_instruction = load_q;
  assign pc_reset         = pc_reset_q;
  assign busy             = busy_q;
  assign done             = done_q;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  assign error            = error_q;
`else
  assign error            = 1'b0;
`endif

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: table vectors, a mid-load reset sequence and randomized loads scored
// against a transaction-level model (expected word list, addresses, byte consumption, end state).
`timescale 1ns/1ps
module tb_program_loader;

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  localparam bit CSUM_ON = 1'b1;
`else
  localparam bit CSUM_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] word_count;
  logic [7:0]  byte_in;
  logic        byte_valid;

  logic        byte_ready_a, load_instruction_a, pc_reset_a, busy_a, done_a, error_a;
  logic [15:0] instruction_in_a, load_address_a;
  logic        byte_ready_b, load_instruction_b, pc_reset_b, busy_b, done_b, error_b;
  logic [15:0] instruction_in_b, load_address_b;

  program_loader #(.BASE_ADDR(16'h0000)) dut_a (
    .clk(clk), .reset(reset), .start(start), .word_count(word_count),
    .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready_a),
    .instruction_in(instruction_in_a), .load_address(load_address_a),
    .load_instruction(load_instruction_a), .pc_reset(pc_reset_a),
    .busy(busy_a), .done(done_a), .error(error_a)
  );

  // Second instance shares all inputs and checks address wrap from the top of memory
  program_loader #(.BASE_ADDR(16'hFFFF)) dut_b (
    .clk(clk), .reset(reset), .start(start), .word_count(word_count),
    .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready_b),
    .instruction_in(instruction_in_b), .load_address(load_address_b),
    .load_instruction(load_instruction_b), .pc_reset(pc_reset_b),
    .busy(busy_b), .done(done_b), .error(error_b)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0]  prog_q[$];
  logic [15:0] data_a[$];
  logic [15:0] addr_a[$];
  logic [15:0] addr_b[$];
  int          cycles_used;

  typedef struct {
    logic [15:0] wc;
    logic [31:0] bytes;
    int          mode;
    bit          abort_first;
    int          nwr;
    logic [15:0] w0;
    logic [15:0] w1;
  } vec_t;

  vec_t vt [4];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // mode 0: byte_valid held high, 1: toggles every other cycle, 2: random valid plus stray start pulses
  task automatic applyStimulus(input logic [15:0] wc, input int mode, input bit bad_csum);
    logic [7:0]  send_q[$];
    logic [7:0]  sum;
    logic [15:0] exp_b;
    bit          take, vld, finished, exp_err;
    int          n_exp;
    sum = 8'h00;
    foreach (prog_q[i]) sum ^= prog_q[i];
    send_q = prog_q;
    if (CSUM_ON) send_q.push_back(bad_csum ? (sum ^ 8'h01) : sum);
    exp_err = bad_csum & CSUM_ON;
    data_a.delete();
    addr_a.delete();
    addr_b.delete();

    @(negedge clk);
    start      = 1'b1;
    word_count = wc;
    byte_valid = 1'b1;
    byte_in    = 8'hEE;
    take       = byte_ready_a;
    cycles_used = 0;
    finished    = 1'b0;
    for (int g = 0; g < 400 && !finished; g++) begin
      @(negedge clk);
      start = 1'b0;
      cycles_used++;
      if (take && send_q.size() > 0) void'(send_q.pop_front());
      if (load_instruction_a) begin
        data_a.push_back(instruction_in_a);
        addr_a.push_back(load_address_a);
      end
      if (load_instruction_b) addr_b.push_back(load_address_b);
      if (done_a || error_a) begin
        finished = 1'b1;
      end else begin
        checkOutput("busy_pc_reset_during_load", {30'd0, busy_a, pc_reset_a}, 32'd3);
        start      = (mode == 2) && ($urandom_range(0, 3) == 0);
        word_count = start ? 16'($urandom) : wc;
        if (mode == 0)      vld = 1'b1;
        else if (mode == 1) vld = ((cycles_used % 2) == 0);
        else                vld = ($urandom_range(0, 1) == 1);
        if (send_q.size() == 0) vld = 1'b0;
        byte_valid = vld;
        byte_in    = vld ? send_q[0] : 8'($urandom);
        take       = byte_ready_a && vld;
      end
    end
    start      = 1'b0;
    byte_valid = 1'b0;

    n_exp = int'(wc);
    checkOutput("load_finished", {31'd0, finished}, 32'd1);
    checkOutput("write_count_a", data_a.size(), n_exp);
    checkOutput("write_count_b", addr_b.size(), n_exp);
    for (int i = 0; i < n_exp && i < data_a.size(); i++) begin
      checkOutput("write_data", data_a[i], {prog_q[2*i], prog_q[2*i+1]});
      checkOutput("write_addr_a", addr_a[i], 16'(i));
    end
    for (int i = 0; i < n_exp && i < addr_b.size(); i++) begin
      exp_b = 16'hFFFF + 16'(i);
      checkOutput("write_addr_b", addr_b[i], exp_b);
    end
    checkOutput("bytes_consumed", send_q.size(), 0);
    checkOutput("final_done", {31'd0, done_a}, {31'd0, !exp_err});
    checkOutput("final_error", {31'd0, error_a}, {31'd0, exp_err});
    checkOutput("final_pc_reset", {31'd0, pc_reset_a}, {31'd0, exp_err});
    checkOutput("final_busy", {31'd0, busy_a}, 32'd0);
    checkOutput("final_byte_ready", {31'd0, byte_ready_a}, 32'd0);
    if (mode == 0) checkOutput("latency", cycles_used, 3 * n_exp + 1 + int'(CSUM_ON));
  endtask

  // Reset lands while the high byte of a word is already captured
  task automatic abort_mid_load();
    @(negedge clk);
    start      = 1'b1;
    word_count = 16'd1;
    byte_valid = 1'b0;
    @(negedge clk);
    start      = 1'b0;
    byte_valid = 1'b1;
    byte_in    = 8'hA5;
    @(negedge clk);
    byte_valid = 1'b0;
    checkOutput("abort_in_lo_busy", {31'd0, busy_a}, 32'd1);
    #2 reset = 1'b1;
    #1;
    checkOutput("abort_busy", {31'd0, busy_a}, 32'd0);
    checkOutput("abort_byte_ready", {31'd0, byte_ready_a}, 32'd0);
    checkOutput("abort_pc_reset", {31'd0, pc_reset_a}, 32'd1);
    checkOutput("abort_instr", {16'd0, instruction_in_a}, 32'd0);
    checkOutput("abort_addr", {16'd0, load_address_a}, 32'd0);
    checkOutput("abort_load", {31'd0, load_instruction_a}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("abort_idle_no_write", {30'd0, load_instruction_a, done_a}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [15:0] wc;
    vt[0] = '{16'd2, 32'h1234ABCD, 0, 1'b0, 2, 16'h1234, 16'hABCD};
    vt[1] = '{16'd1, 32'h80010000, 1, 1'b0, 1, 16'h8001, 16'h0000};
    vt[2] = '{16'd0, 32'h00000000, 0, 1'b0, 0, 16'h0000, 16'h0000};
    vt[3] = '{16'd1, 32'h0F0F0000, 0, 1'b1, 1, 16'h0F0F, 16'h0000};

    reset      = 1'b1;
    start      = 1'b0;
    word_count = 16'd0;
    byte_in    = 8'h00;
    byte_valid = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rst_instr", {16'd0, instruction_in_a}, 32'd0);
    checkOutput("rst_addr_a", {16'd0, load_address_a}, 32'h0000);
    checkOutput("rst_addr_b", {16'd0, load_address_b}, 32'hFFFF);
    checkOutput("rst_flags", {26'd0, load_instruction_a, pc_reset_a, byte_ready_a, busy_a, done_a, error_a},
                32'b010000);
    reset = 1'b0;

    for (int i = 0; i < 4; i++) begin
      if (vt[i].abort_first) abort_mid_load();
      prog_q.delete();
      for (int k = 0; k < 2 * int'(vt[i].wc); k++) prog_q.push_back(vt[i].bytes[31 - 8*k -: 8]);
      applyStimulus(vt[i].wc, vt[i].mode, 1'b0);
      checkOutput("tbl_nwr", data_a.size(), vt[i].nwr);
      if (vt[i].nwr > 0 && data_a.size() > 0) checkOutput("tbl_w0", data_a[0], vt[i].w0);
      if (vt[i].nwr > 1 && data_a.size() > 1) checkOutput("tbl_w1", data_a[1], vt[i].w1);
    end

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    prog_q.delete();
    prog_q.push_back(8'h12);
    prog_q.push_back(8'h34);
    applyStimulus(16'd1, 0, 1'b0);
    checkOutput("csum_good_done", {31'd0, done_a}, 32'd1);
    applyStimulus(16'd1, 0, 1'b1);
    checkOutput("csum_bad_error", {30'd0, error_a, pc_reset_a}, 32'd3);
`endif

    for (int r = 0; r < 25; r++) begin
      wc = 16'($urandom_range(0, 6));
      prog_q.delete();
      for (int k = 0; k < 2 * int'(wc); k++) prog_q.push_back(8'($urandom));
      applyStimulus(wc, int'($urandom_range(0, 2)), ($urandom_range(0, 3) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
